// File: rtl/gray_counter_enc.sv
// Up/down binary counter with a registered Gray-code image of the count.
// Both encodings and the wrap flag are registered on the same edge, so they never skew.
module gray_counter_enc #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         wrap
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] bin_reg, bin_next;
  logic [N-1:0] gray_reg, gray_next;
  logic         wrap_reg, wrap_next;

  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up) begin
        bin_next  = bin_reg + ONE;
        wrap_next = (bin_reg == ALL_ONES);
      end else begin
        bin_next  = bin_reg - ONE;
        wrap_next = (bin_reg == '0);
      end
    end
  end

  // Gray is formed from the next binary value, not the registered one, to avoid a cycle of lag.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate
  assign gray_next[N-1] = bin_next[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bin_out  = bin_reg;
  assign gray_out = gray_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_gray_counter_enc.sv
// Bench for gray_counter_enc: directed scenarios followed by random traffic,
// all checked against an arithmetic model of the count.
module tb_gray_counter_enc;

  localparam int N = 4;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         wrap;

  int vectors = 0;
  int miscompares = 0;
  int m_bin = 0;
  bit m_wrap = 1'b0;
  bit was_reset = 1'b0;
  logic [3:0] seq [16];

  gray_counter_enc #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, and compare all outputs.
  task automatic step(input logic r, input logic e, input logic u, input logic l, input int lv);
    logic [N-1:0] prev_g;
    prev_g   = gray_out;
    rst      = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv[N-1:0];
    @(posedge clk);
    #1;
    if (r) begin
      m_bin = 0; m_wrap = 0;
    end else if (l) begin
      m_bin = lv % M; m_wrap = 0;
    end else if (e && u) begin
      m_wrap = (m_bin == M - 1); m_bin = (m_bin + 1) % M;
    end else if (e) begin
      m_wrap = (m_bin == 0); m_bin = (m_bin + M - 1) % M;
    end else begin
      m_wrap = 0;
    end
    check("bin", {28'd0, bin_out}, m_bin);
    check("gray", {28'd0, gray_out}, m_bin ^ (m_bin >> 1));
    check("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    if (was_reset && !r && !l && e)
      check("onebit", $countones(prev_g ^ gray_out), 1);
    if (r) was_reset = 1'b1;
    $display("rst=%0d en=%0d up=%0d load=%0d lv=%0d -> bin=%0d gray=%b wrap=%0d",
             r, e, u, l, lv, bin_out, gray_out, wrap);
  endtask

  initial begin
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
            4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    @(negedge clk);

    // reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("t1_bin", {28'd0, bin_out}, 0);
      check("t1_wrap", {31'd0, wrap}, 0);
    end

    // full up count
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0, 0);
      check("t2_gray", {28'd0, gray_out}, {28'd0, seq[i]});
      check("t2_wrap", {31'd0, wrap}, (i == 15) ? 1 : 0);
    end

    // load then decrement
    step(0, 0, 0, 1, 10);
    check("t3_gray", {28'd0, gray_out}, 32'b1111);
    step(0, 1, 0, 0, 0);
    check("t3_bin", {28'd0, bin_out}, 9);
    check("t3_gray2", {28'd0, gray_out}, 32'b1101);

    // decrement wrap from 0
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("t4_bin", {28'd0, bin_out}, 15);
    check("t4_gray", {28'd0, gray_out}, 32'b1000);
    check("t4_wrap", {31'd0, wrap}, 1);
    step(0, 0, 0, 0, 0);
    check("t4_hold", {28'd0, bin_out}, 15);
    check("t4_wrap0", {31'd0, wrap}, 0);

    // load beats increment at the top
    step(0, 1, 1, 1, 3);
    check("t5_bin", {28'd0, bin_out}, 3);
    check("t5_gray", {28'd0, gray_out}, 32'b0010);
    check("t5_wrap", {31'd0, wrap}, 0);

    // reset mid-count beats load and en
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    check("t6_gray", {28'd0, gray_out}, 32'b0101);
    step(1, 1, 1, 1, 9);
    check("t6_rst", {28'd0, bin_out}, 0);
    step(0, 1, 1, 0, 0);
    check("t6_gray2", {28'd0, gray_out}, 32'b0001);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), $urandom_range(0, M - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
